// File: rtl/kbd_matrix_scan_if.sv
// Keypad-side bundle: matrix pins plus the key/ready/ack handshake to the CPU I/O block.
interface kbd_matrix_scan_if;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] KEY;
  logic       READY;
  logic       ACK;
  logic       OVR;
  logic       PRESSED;

  modport master (
    input  ROW, ACK,
    output COL, KEY, READY, OVR, PRESSED
  );

  modport slave (
    output ROW, ACK,
    input  COL, KEY, READY, OVR, PRESSED
  );
endinterface

// File: rtl/kbd_matrix_scan.sv
// 4x4 key matrix scanner: column drive, full-scan debounce, single-key event reporting
// with a ready/ack handshake and sticky overrun flag.
module kbd_matrix_scan #(
  parameter int in_clock  = 50_000_000,
  parameter int col_rate  = 1000,
  parameter int deb_scans = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  kbd_matrix_scan_if.master bus
);

  localparam int clk_val = in_clock / col_rate - 1;
  localparam int reg_val = (clk_val > 0) ? $clog2(clk_val + 1) : 1;
  localparam logic [reg_val-1:0] presc_last  = reg_val'(clk_val);
  localparam logic [3:0]         stable_goal = 4'(deb_scans - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    MULTI = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [15:0] v);
    is_onehot = (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  function automatic logic [3:0] bit_index(input logic [15:0] v);
    bit_index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) bit_index = 4'(i);
    end
  endfunction

  logic [3:0]         row_meta_r, row_sync_r;
  logic [reg_val-1:0] presc_r;
  logic [1:0]         col_r;
  logic [1:0]         col_nxt_s;
  logic [3:0]         col_out_r;
  logic [15:0]        snap_r, prev_r, deb_r;
  logic [15:0]        snap_done_s;
  logic [3:0]         stable_r, stable_next_s;
  logic               tick_s, scan_end_s;
  state_t             state_r, state_nxt_s;
  logic               event_s;
  logic [3:0]         code_s;
  logic [3:0]         key_r;
  logic               ready_r, ovr_r, pressed_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= bus.ROW;
      row_sync_r <= row_meta_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      presc_r <= '0;
    else if (tick_s) presc_r <= '0;
    else             presc_r <= presc_r + 1'b1;
  end

  // The column being sampled has been driven for a whole prescaler period.
  always_comb begin
    tick_s      = (presc_r == presc_last);
    scan_end_s  = tick_s && (col_r == 2'd3);
    col_nxt_s   = col_r + 2'd1;
    snap_done_s = snap_r;
    snap_done_s[{col_r, 2'b00} +: 4] = ~row_sync_r;
    if (snap_done_s == prev_r) begin
      stable_next_s = (stable_r == 4'hF) ? stable_r : stable_r + 4'd1;
    end else begin
      stable_next_s = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r     <= 2'd0;
      col_out_r <= 4'b1110;
      snap_r    <= 16'd0;
      prev_r    <= 16'd0;
      stable_r  <= 4'd0;
      deb_r     <= 16'd0;
    end else if (tick_s) begin
      snap_r    <= snap_done_s;
      col_r     <= col_nxt_s;
      col_out_r <= ~(4'b0001 << col_nxt_s);
      if (scan_end_s) begin
        prev_r   <= snap_done_s;
        stable_r <= stable_next_s;
        if (stable_next_s >= stable_goal) deb_r <= snap_done_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (deb_r == 16'd0)     state_nxt_s = IDLE;
        else if (is_onehot(deb_r)) state_nxt_s = HELD;
        else                    state_nxt_s = MULTI;
      end
      HELD: begin
        if (deb_r == 16'd0)     state_nxt_s = IDLE;
        else if (is_onehot(deb_r)) state_nxt_s = HELD;
        else                    state_nxt_s = MULTI;
      end
      MULTI: begin
        if (deb_r == 16'd0) state_nxt_s = IDLE;
        else                state_nxt_s = MULTI;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  always_comb begin
    event_s = 1'b0;
    code_s  = bit_index(deb_r);
    case (state_r)
      IDLE:    event_s = is_onehot(deb_r);
      HELD:    event_s = 1'b0;
      MULTI:   event_s = 1'b0;
      default: event_s = 1'b0;
    endcase
  end

  // A press arriving with an unread code is dropped unless the CPU acks in the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r     <= 4'd0;
      ready_r   <= 1'b0;
      ovr_r     <= 1'b0;
      pressed_r <= 1'b0;
    end else begin
      pressed_r <= |deb_r;
      if (event_s) begin
        if (!ready_r) begin
          key_r   <= code_s;
          ready_r <= 1'b1;
        end else if (!bus.ACK) begin
          ovr_r <= 1'b1;
        end else begin
          key_r <= code_s;
        end
      end else if (bus.ACK && ready_r) begin
        ready_r <= 1'b0;
        ovr_r   <= 1'b0;
      end
    end
  end

  assign bus.COL     = col_out_r;
  assign bus.KEY     = key_r;
  assign bus.READY   = ready_r;
  assign bus.OVR     = ovr_r;
  assign bus.PRESSED = pressed_r;

endmodule
